// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard control: load-use/branch stalls, ID forwarding, MDU busy stall (macro HAZARD_CTRL_MDU_EN)
module hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs_id,
    input  logic [4:0] rt_id,
    input  logic       branch_id,
    input  logic       hilo_op_id,
    input  logic       reg_write_ex,
    input  logic       mem_read_ex,
    input  logic [4:0] reg_w_addr_ex,
    input  logic       reg_write_mem,
    input  logic       mem_read_mem,
    input  logic [4:0] reg_w_addr_mem,
    input  logic       mdu_start_ex,
    input  logic       mdu_div_ex,
    output logic       stall_if,
    output logic       bubble_ex,
    output logic       forward_a_id,
    output logic       forward_b_id,
    output logic       mdu_busy
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic w_ex_hit_rs;
    logic w_ex_hit_rt;
    logic w_mem_hit_rs;
    logic w_mem_hit_rt;
    logic w_ex_hit;
    logic w_mem_hit;
    logic w_load_use;
    logic w_branch_alu;
    logic w_branch_load_mem;
    logic w_hold_entry;
    logic w_mdu_stall;

    // Register 0 is hardwired, so a write to it never creates a dependency.
    assign w_ex_hit_rs  = reg_write_ex  && (reg_w_addr_ex  != 5'd0) && (reg_w_addr_ex  == rs_id);
    assign w_ex_hit_rt  = reg_write_ex  && (reg_w_addr_ex  != 5'd0) && (reg_w_addr_ex  == rt_id);
    assign w_mem_hit_rs = reg_write_mem && (reg_w_addr_mem != 5'd0) && (reg_w_addr_mem == rs_id);
    assign w_mem_hit_rt = reg_write_mem && (reg_w_addr_mem != 5'd0) && (reg_w_addr_mem == rt_id);
    assign w_ex_hit     = w_ex_hit_rs  || w_ex_hit_rt;
    assign w_mem_hit    = w_mem_hit_rs || w_mem_hit_rt;

    assign w_load_use        = mem_read_ex && w_ex_hit;
    assign w_branch_alu      = branch_id && !mem_read_ex && w_ex_hit;
    assign w_branch_load_mem = branch_id && mem_read_mem && w_mem_hit;
    assign w_hold_entry      = branch_id && mem_read_ex && w_ex_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A load feeding a branch needs a second stall cycle beyond the load-use one.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:  if (w_hold_entry) w_state_next = ST_HOLD;
            ST_HOLD: w_state_next = ST_RUN;
            default: w_state_next = ST_RUN;
        endcase
    end

`ifdef HAZARD_CTRL_MDU_EN
    logic [5:0] r_mdu_cnt;
    logic       r_mdu_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mdu_cnt  <= 6'd0;
            r_mdu_busy <= 1'b0;
        end else if (r_mdu_busy) begin
            if (r_mdu_cnt == 6'd0) begin
                r_mdu_busy <= 1'b0;
            end else begin
                r_mdu_cnt <= r_mdu_cnt - 6'd1;
            end
        end else if (mdu_start_ex) begin
            r_mdu_cnt  <= mdu_div_ex ? 6'(DIV_CYCLES - 1) : 6'(MUL_CYCLES - 1);
            r_mdu_busy <= 1'b1;
        end
    end

    assign w_mdu_stall = r_mdu_busy && hilo_op_id;
    assign mdu_busy    = r_mdu_busy;
`else
    logic w_unused_mdu;
    assign w_unused_mdu = ^{mdu_start_ex, mdu_div_ex, hilo_op_id, 6'(MUL_CYCLES), 6'(DIV_CYCLES)};
    assign w_mdu_stall  = 1'b0;
    assign mdu_busy     = 1'b0;
`endif

    assign stall_if = !rst && (w_load_use || w_branch_alu || w_branch_load_mem
                               || (r_state == ST_HOLD) || w_mdu_stall);
    assign bubble_ex = stall_if;

    // A load still in MEM has no data yet, so only ALU results are forwarded.
    assign forward_a_id = !rst && w_mem_hit_rs && !mem_read_mem;
    assign forward_b_id = !rst && w_mem_hit_rt && !mem_read_mem;

endmodule
